// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path: FSM state encoding,
// SYNC pattern and PID codes.
package usb_rx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, ERR_WAIT} rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // A PID byte carries its code in the low nibble and the complement above it.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

endpackage

// File: rtl/rx_byte_cnt.sv
// Payload byte counter: synchronous clear, increment, and a flag when the
// count has reached MAX_BYTES.
module rx_byte_cnt #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count  = count_q;
    assign at_max = (count_q == CNT_W'(MAX_BYTES));

endmodule

// File: rtl/rx_pkt_ctrl.sv
// USB receive packet sequencer: SYNC/PID checks, payload writes into rx_fifo,
// sticky error. Define RX_PKT_LEN_EN to add the pkt_len/pkt_len_valid outputs.
module rx_pkt_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             byte_done,
    input  logic [7:0]       rx_byte,
    input  logic             eop,
    input  logic             fifo_full,
    output logic             fifo_w_enable,
    output logic [7:0]       fifo_w_data,
    output logic             rcving,
    output logic [3:0]       rx_pid,
    output logic             pid_valid,
    output logic             r_error
`ifdef RX_PKT_LEN_EN
    ,
    output logic [CNT_W-1:0] pkt_len,
    output logic             pkt_len_valid
`endif
);

    rx_state_t        state_q, state_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             rcving_q, rcving_d;
    logic [3:0]       rx_pid_q, rx_pid_d;
    logic             pid_valid_q, pid_valid_d;
    logic             r_error_q, r_error_d;
    logic             cnt_clr, cnt_inc, at_max, drop;
    logic [CNT_W-1:0] count;

    rx_byte_cnt #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count),
        .at_max(at_max)
    );

    assign drop = byte_done && (fifo_full || at_max);

    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        rx_pid_d    = rx_pid_q;
        pid_valid_d = 1'b0;
        r_error_d   = r_error_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: if (d_edge) begin
                state_d   = SYNC;
                r_error_d = 1'b0;
            end
            // eop wins over a coincident byte before payload: the packet is truncated.
            SYNC: if (eop) begin
                state_d   = IDLE;
                r_error_d = 1'b1;
            end else if (byte_done) begin
                if (rx_byte == SYNC_BYTE) begin
                    state_d = PID;
                end else begin
                    state_d   = ERR_WAIT;
                    r_error_d = 1'b1;
                end
            end
            PID: if (eop) begin
                state_d   = IDLE;
                r_error_d = 1'b1;
            end else if (byte_done) begin
                if (pid_ok(rx_byte)) begin
                    state_d     = DATA;
                    rx_pid_d    = rx_byte[3:0];
                    pid_valid_d = 1'b1;
                    cnt_clr     = 1'b1;
                end else begin
                    state_d   = ERR_WAIT;
                    r_error_d = 1'b1;
                end
            end
            // A coincident byte is handled first, then eop closes the packet.
            DATA: begin
                if (drop) begin
                    state_d   = ERR_WAIT;
                    r_error_d = 1'b1;
                end else if (byte_done) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = rx_byte;
                    cnt_inc   = 1'b1;
                end
                if (eop)
                    state_d = IDLE;
            end
            ERR_WAIT: if (eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rcving_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rcving_q    <= 1'b0;
            rx_pid_q    <= '0;
            pid_valid_q <= 1'b0;
            r_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rcving_q    <= rcving_d;
            rx_pid_q    <= rx_pid_d;
            pid_valid_q <= pid_valid_d;
            r_error_q   <= r_error_d;
        end
    end

    assign fifo_w_enable = wr_en_q;
    assign fifo_w_data   = wr_data_q;
    assign rcving        = rcving_q;
    assign rx_pid        = rx_pid_q;
    assign pid_valid     = pid_valid_q;
    assign r_error       = r_error_q;

`ifdef RX_PKT_LEN_EN
    logic [CNT_W-1:0] pkt_len_q, pkt_len_d;
    logic             pkt_len_valid_q, pkt_len_valid_d;

    always_comb begin
        pkt_len_d       = pkt_len_q;
        pkt_len_valid_d = 1'b0;
        if (state_q == DATA && eop && !drop) begin
            pkt_len_d       = count + CNT_W'(cnt_inc);
            pkt_len_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_len_q       <= '0;
            pkt_len_valid_q <= 1'b0;
        end else begin
            pkt_len_q       <= pkt_len_d;
            pkt_len_valid_q <= pkt_len_valid_d;
        end
    end

    assign pkt_len       = pkt_len_q;
    assign pkt_len_valid = pkt_len_valid_q;
`endif

endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Self-checking bench for rx_pkt_ctrl: directed packets plus randomized packets
// checked against a per-packet reference model.
module tb_rx_pkt_ctrl;

    localparam int MAX   = 64;
    localparam int CNT_W = $clog2(MAX + 1);

    logic clk = 1'b0, n_rst = 1'b0;
    logic d_edge = 1'b0, byte_done = 1'b0, eop = 1'b0, fifo_full = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic fifo_w_enable, rcving, pid_valid, r_error;
    logic [7:0] fifo_w_data;
    logic [3:0] rx_pid;
`ifdef RX_PKT_LEN_EN
    logic [CNT_W-1:0] pkt_len;
    logic             pkt_len_valid;
`endif

    rx_pkt_ctrl #(.MAX_BYTES(MAX)) dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_done(byte_done),
        .rx_byte(rx_byte), .eop(eop), .fifo_full(fifo_full),
        .fifo_w_enable(fifo_w_enable), .fifo_w_data(fifo_w_data),
        .rcving(rcving), .rx_pid(rx_pid), .pid_valid(pid_valid), .r_error(r_error)
`ifdef RX_PKT_LEN_EN
        , .pkt_len(pkt_len), .pkt_len_valid(pkt_len_valid)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet under test: pb = SYNC, PID, payload...; pf = fifo_full seen with each byte.
    logic [7:0] pb[$];
    bit         pf[$];
    bit         exp_wr[$], exp_pv[$], exp_er[$];
    bit         exp_ok;
    int         exp_len;
    logic [3:0] last_pid = 4'h0;
    int         last_len = 0;

    // Walks the packet byte by byte from the protocol rules.
    task automatic model(input bit eop_same);
        bit ok = 1'b1;
        int written = 0;
        int n = pb.size();
        exp_wr.delete(); exp_pv.delete(); exp_er.delete();
        for (int i = 0; i < n; i++) begin
            bit last_eop = eop_same && (i == n - 1);
            bit wr = 1'b0, pv = 1'b0;
            if (ok) begin
                if (i == 0) begin
                    if (last_eop || pb[0] != 8'h80) ok = 1'b0;
                end else if (i == 1) begin
                    if (last_eop || pb[1][7:4] != ~pb[1][3:0]) ok = 1'b0;
                    else pv = 1'b1;
                end else begin
                    if (pf[i] || written == MAX) ok = 1'b0;
                    else begin wr = 1'b1; written++; end
                end
            end
            exp_wr.push_back(wr);
            exp_pv.push_back(pv);
            exp_er.push_back(!ok);
        end
        if (ok && n < 2) ok = 1'b0;
        exp_ok  = ok;
        exp_len = written;
    endtask

    task automatic run_pkt(input bit eop_same, input bit rand_gaps);
        int n;
        model(eop_same);
        n = pb.size();
        d_edge = 1'b1;
        @(posedge clk); #1 d_edge = 1'b0;
        chk("rcving_start", rcving, 1);
        chk("rerr_clear", r_error, 0);
        for (int i = 0; i < n; i++) begin
            int gap = rand_gaps ? $urandom_range(0, 2) : 0;
            repeat (gap) begin
                d_edge = 1'($urandom_range(0, 1));
                @(posedge clk); #1 d_edge = 1'b0;
                chk("gap_no_wr", fifo_w_enable, 0);
                chk("gap_no_pidv", pid_valid, 0);
            end
            byte_done = 1'b1; rx_byte = pb[i]; fifo_full = pf[i];
            eop = eop_same && (i == n - 1);
            @(posedge clk); #1;
            byte_done = 1'b0; fifo_full = 1'b0; eop = 1'b0;
            chk("wr_en", fifo_w_enable, exp_wr[i]);
            if (exp_wr[i]) chk("wr_data", fifo_w_data, pb[i]);
            chk("pid_valid", pid_valid, exp_pv[i]);
            chk("r_error_mid", r_error, exp_er[i]);
            chk("rcving_mid", rcving, (eop_same && i == n - 1) ? 0 : 1);
            if (exp_pv[i]) last_pid = pb[i][3:0];
        end
        if (!eop_same || n == 0) begin
            eop = 1'b1;
            @(posedge clk); #1 eop = 1'b0;
            chk("eop_no_wr", fifo_w_enable, 0);
        end
        chk("rcving_end", rcving, 0);
        chk("r_error_end", r_error, !exp_ok);
        chk("rx_pid", rx_pid, last_pid);
`ifdef RX_PKT_LEN_EN
        chk("pkt_len_valid", pkt_len_valid, exp_ok);
        if (exp_ok) last_len = exp_len;
        chk("pkt_len", pkt_len, last_len);
`endif
        @(posedge clk); #1;
        chk("idle_rcving", rcving, 0);
        chk("idle_r_error", r_error, !exp_ok);
`ifdef RX_PKT_LEN_EN
        chk("pkt_len_valid_pulse", pkt_len_valid, 0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wen"}, fifo_w_enable, 0);
        chk({tag, "_wdata"}, fifo_w_data, 0);
        chk({tag, "_rcving"}, rcving, 0);
        chk({tag, "_pid"}, rx_pid, 0);
        chk({tag, "_pidv"}, pid_valid, 0);
        chk({tag, "_rerr"}, r_error, 0);
`ifdef RX_PKT_LEN_EN
        chk({tag, "_len"}, pkt_len, 0);
        chk({tag, "_lenv"}, pkt_len_valid, 0);
`endif
    endtask

    initial begin
        #1 chk_all_zero("reset");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        byte_done = 1'b1; rx_byte = 8'h80; eop = 1'b1;
        @(posedge clk); #1 byte_done = 1'b0; eop = 1'b0;
        chk_all_zero("idle_ignores");

        // Good DATA0 packet with three payload bytes.
        pb = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33}; pf = '{0, 0, 0, 0, 0};
        run_pkt(1'b0, 1'b0);
        // Bad SYNC, then a clean packet clears the error.
        pb = '{8'h81, 8'hC3, 8'h44}; pf = '{0, 0, 0};
        run_pkt(1'b0, 1'b0);
        pb = '{8'h80, 8'h4B}; pf = '{0, 0};
        run_pkt(1'b0, 1'b0);
        // Bad PID complement.
        pb = '{8'h80, 8'hC4, 8'h55, 8'h66}; pf = '{0, 0, 0, 0};
        run_pkt(1'b0, 1'b0);
        // fifo_full on the second payload byte.
        pb = '{8'h80, 8'hD2, 8'hA1, 8'hA2, 8'hA3}; pf = '{0, 0, 0, 1, 0};
        run_pkt(1'b0, 1'b0);
        // MAX+1 payload bytes overflows.
        pb = '{8'h80, 8'hE1}; pf = '{0, 0};
        for (int i = 0; i <= MAX; i++) begin pb.push_back(8'(i + 1)); pf.push_back(1'b0); end
        run_pkt(1'b0, 1'b0);
        // Exactly MAX bytes with eop on the last one: no error.
        pb = '{8'h80, 8'h4B}; pf = '{0, 0};
        for (int i = 0; i < MAX; i++) begin pb.push_back(8'(8'hF0 - i)); pf.push_back(1'b0); end
        run_pkt(1'b1, 1'b0);
        // eop coincident with a payload byte.
        pb = '{8'h80, 8'h5A, 8'h77, 8'h88}; pf = '{0, 0, 0, 0};
        run_pkt(1'b1, 1'b0);
        // Truncated after SYNC, and zero-payload packet.
        pb = '{8'h80}; pf = '{0};
        run_pkt(1'b0, 1'b0);
        pb = '{8'h80, 8'hD2}; pf = '{0, 0};
        run_pkt(1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int np;
            logic [7:0] b;
            logic [3:0] p;
            pb.delete(); pf.delete();
            b = 8'($urandom);
            pb.push_back(($urandom_range(0, 7) == 0 && b != 8'h80) ? b : 8'h80);
            p = 4'($urandom);
            pb.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom) : {~p, p});
            np = ($urandom_range(0, 11) == 0) ? MAX + $urandom_range(0, 2) : $urandom_range(0, 6);
            for (int i = 0; i < np; i++) pb.push_back(8'($urandom));
            for (int i = 0; i < pb.size(); i++) pf.push_back(i >= 2 && $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) while (pb.size() > $urandom_range(0, 1)) void'(pb.pop_back());
            run_pkt(1'($urandom_range(0, 3) == 0), 1'b1);
        end

        // Reset in the middle of DATA cancels the pending write strobe.
        d_edge = 1'b1; @(posedge clk); #1 d_edge = 1'b0;
        byte_done = 1'b1; rx_byte = 8'h80; @(posedge clk); #1;
        rx_byte = 8'hC3; @(posedge clk); #1;
        rx_byte = 8'h99; @(posedge clk); #1 byte_done = 1'b0;
        chk("pre_rst_wen", fifo_w_enable, 1);
        chk("pre_rst_wdata", fifo_w_data, 8'h99);
        #2 n_rst = 1'b0;
        #1 chk_all_zero("mid_rst");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1 chk("post_rst_rcving", rcving, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
